// File: rtl/aexm_dmem_resp.sv
// AEXM data-side responder: a direct-mapped, write-through, one-word-per-line cache.
// Load misses and every store go out on the req/ack port and stall the pipeline.
`timescale 1ns/1ps
module aexm_dmem_resp #(
    parameter int INDEX_BITS = 6
) (
    input  logic        gclk,
    input  logic        grst,
    input  logic        d_en,
    input  logic        dSTRLOD,
    input  logic        dLOD,
    input  logic        aexm_dcache_precycle_we,
    input  logic        aexm_dcache_force_miss,
    input  logic [31:0] xADDR,
    input  logic [31:0] xDATA,
    input  logic [3:0]  xSEL,
    output logic [31:0] dcache_rdata,
    output logic        dcache_rvalid,
    output logic        dcache_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_sel,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t state, state_nxt;

    logic                  xop, xlod;
    logic [LINES-1:0]      valid;
    logic [TAG_W-1:0]      tags [LINES];
    logic [31:0]           data [LINES];

    logic [INDEX_BITS-1:0] idx, fill_idx;
    logic [TAG_W-1:0]      xtag;
    logic                  hit, is_load, is_store;
    logic                  ld_hit, ld_miss, st_go, ack_rd, ack_wr;
    logic                  unused_ok;

    assign idx      = xADDR[INDEX_BITS+1:2];
    assign xtag     = xADDR[31:INDEX_BITS+2];
    // Fills address the line through the held request, not the execute inputs.
    assign fill_idx = mem_addr[INDEX_BITS+1:2];
    assign hit      = valid[idx] && (tags[idx] == xtag);
    assign is_load  = xop && xlod;
    assign is_store = xop && !xlod;
    assign ld_hit   = (state == IDLE) && is_load && hit && !aexm_dcache_force_miss;
    assign ld_miss  = (state == IDLE) && is_load && (!hit || aexm_dcache_force_miss);
    assign st_go    = (state == IDLE) && is_store;
    assign ack_rd   = (state == READ) && mem_ack;
    assign ack_wr   = (state == WRITE) && mem_ack;

    // The store strobe is redundant with xop/xlod, which decide the operation.
    assign unused_ok = &{1'b0, aexm_dcache_precycle_we, xADDR[1:0]};

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ld_miss) state_nxt = READ;
                     else if (st_go) state_nxt = WRITE;
            READ:    if (mem_ack) state_nxt = RESP;
            WRITE:   if (mem_ack) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dcache_stall = 1'b0;
        case (state)
            IDLE:        dcache_stall = ld_miss || st_go;
            READ, WRITE: dcache_stall = 1'b1;
            default:     dcache_stall = 1'b0;
        endcase
    end

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            xop           <= 1'b0;
            xlod          <= 1'b0;
            valid         <= '0;
            dcache_rdata  <= '0;
            dcache_rvalid <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_sel       <= '0;
        end else begin
            dcache_rvalid <= ld_hit || ack_rd;
            if (d_en) begin
                xop  <= dSTRLOD;
                xlod <= dLOD;
            end else if (ld_hit || state == RESP) begin
                xop  <= 1'b0;
                xlod <= 1'b0;
            end
            if (ld_hit)      dcache_rdata <= data[idx];
            else if (ack_rd) dcache_rdata <= mem_rdata;
            if (ld_miss)     valid[idx] <= 1'b0;
            else if (ack_rd) valid[fill_idx] <= 1'b1;
            if (ld_miss || st_go) begin
                mem_req  <= 1'b1;
                mem_we   <= st_go;
                mem_addr <= {xADDR[31:2], 2'b00};
                if (st_go) begin
                    mem_wdata <= xDATA;
                    mem_sel   <= xSEL;
                end
            end else if (ack_rd || ack_wr) begin
                mem_req <= 1'b0;
            end
        end
    end

    // Tag/data arrays need no reset: valid[] gates every use.
    always_ff @(posedge gclk) begin
        if (ack_rd) begin
            tags[fill_idx] <= mem_addr[31:INDEX_BITS+2];
            data[fill_idx] <= mem_rdata;
        end else if (st_go && hit) begin
            for (int unsigned b = 0; b < 4; b++)
                if (xSEL[b]) data[idx][8*b +: 8] <= xDATA[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_aexm_dmem_resp.sv
// Directed bench for aexm_dmem_resp: miss/hit timing, store merge, conflicts,
// force_miss, delayed and stray acks, async reset mid-read, no write-allocate.
`timescale 1ns/1ps
module tb_aexm_dmem_resp;
    logic        gclk = 1'b0, grst = 1'b1;
    logic        d_en = 1'b0, dSTRLOD = 1'b0, dLOD = 1'b0;
    logic        pwe = 1'b0, fmiss = 1'b0;
    logic [31:0] xADDR = '0, xDATA = '0, mem_rdata = '0;
    logic [3:0]  xSEL = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] dcache_rdata, mem_addr, mem_wdata;
    logic        dcache_rvalid, dcache_stall, mem_req, mem_we;
    logic [3:0]  mem_sel;
    int checks = 0, errors = 0;

    aexm_dmem_resp #(.INDEX_BITS(6)) dut (
        .gclk(gclk), .grst(grst), .d_en(d_en), .dSTRLOD(dSTRLOD), .dLOD(dLOD),
        .aexm_dcache_precycle_we(pwe), .aexm_dcache_force_miss(fmiss),
        .xADDR(xADDR), .xDATA(xDATA), .xSEL(xSEL),
        .dcache_rdata(dcache_rdata), .dcache_rvalid(dcache_rvalid), .dcache_stall(dcache_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_sel(mem_sel), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    // Load an op through decode; returns settled inside its lookup cycle T.
    task automatic issue(input logic [31:0] a, input logic lod, input logic fm,
                         input logic [31:0] d, input logic [3:0] s);
        d_en = 1'b1; dSTRLOD = 1'b1; dLOD = lod; pwe = !lod; fmiss = fm;
        xADDR = a; xDATA = d; xSEL = s;
        tick();
        d_en = 1'b0; dSTRLOD = 1'b0; dLOD = 1'b0;
        #1;
    endtask

    // From cycle T: check the request, wait 'extra' cycles, ack, end in the RESP cycle.
    task automatic serve(input int extra, input logic [31:0] a, input logic we,
                         input logic [31:0] rd);
        tick();
        chk("req_up", mem_req, 1); chk("req_addr", mem_addr, a);
        chk("req_we", mem_we, we); chk("req_stall", dcache_stall, 1);
        if (we) begin
            chk("req_wdata", mem_wdata, xDATA); chk("req_sel", mem_sel, xSEL);
        end
        for (int i = 0; i < extra; i++) begin
            tick();
            chk("hold_req", mem_req, 1); chk("hold_addr", mem_addr, a);
            chk("hold_stall", dcache_stall, 1);
        end
        mem_ack = 1'b1; mem_rdata = rd;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        chk("resp_rvalid", dcache_rvalid, !we);
        chk("resp_stall", dcache_stall, 0);
        chk("resp_req", mem_req, 0);
    endtask

    initial begin
        #2;
        chk("rst_req", mem_req, 0); chk("rst_stall", dcache_stall, 0);
        chk("rst_rvalid", dcache_rvalid, 0); chk("rst_rdata", dcache_rdata, 0);
        chk("rst_addr", mem_addr, 0);
        tick();
        grst = 1'b0;
        tick();

        // Cold miss on 0x100, ack at T+3.
        issue(32'h100, 1, 0, 0, 0);
        chk("miss_stall_T", dcache_stall, 1); chk("miss_noreq_T", mem_req, 0);
        serve(2, 32'h100, 0, 32'hDEADBEEF);
        chk("miss_rdata", dcache_rdata, 32'hDEADBEEF);
        tick();
        chk("idle_rvalid", dcache_rvalid, 0);

        // Reload hits.
        issue(32'h100, 1, 0, 0, 0);
        chk("hit_stall", dcache_stall, 0);
        tick();
        chk("hit_rvalid", dcache_rvalid, 1); chk("hit_rdata", dcache_rdata, 32'hDEADBEEF);
        chk("hit_noreq", mem_req, 0);
        tick();
        chk("hit_rvalid_1cyc", dcache_rvalid, 0);

        // Fill 0x104 with the earliest ack, then two back-to-back hits.
        issue(32'h104, 1, 0, 0, 0);
        serve(0, 32'h104, 0, 32'hCAFEF00D);
        tick();
        d_en = 1'b1; dSTRLOD = 1'b1; dLOD = 1'b1; xADDR = 32'h0;
        tick();
        xADDR = 32'h100; #1;
        chk("b2b_stall0", dcache_stall, 0);
        tick();
        d_en = 1'b0; dSTRLOD = 1'b0; dLOD = 1'b0; xADDR = 32'h104; #1;
        chk("b2b_stall1", dcache_stall, 0);
        chk("b2b_rv0", dcache_rvalid, 1); chk("b2b_rd0", dcache_rdata, 32'hDEADBEEF);
        tick();
        chk("b2b_rv1", dcache_rvalid, 1); chk("b2b_rd1", dcache_rdata, 32'hCAFEF00D);
        tick();
        chk("b2b_end", dcache_rvalid, 0);

        // Store hit with byte merge, then load sees merged data.
        issue(32'h100, 0, 0, 32'h11223344, 4'b0011);
        chk("st_stall_T", dcache_stall, 1);
        serve(0, 32'h100, 1, 0);
        tick();
        issue(32'h100, 1, 0, 0, 0);
        chk("merge_hit", dcache_stall, 0);
        tick();
        chk("merge_rdata", dcache_rdata, 32'hDEAD3344);
        tick();

        // Conflict: 0x200 shares index 0 with 0x100.
        issue(32'h200, 1, 0, 0, 0);
        chk("conf_miss", dcache_stall, 1);
        serve(0, 32'h200, 0, 32'h22222222);
        chk("conf_rdata", dcache_rdata, 32'h22222222);
        tick();
        issue(32'h100, 1, 0, 0, 0);
        chk("evict_miss", dcache_stall, 1);
        serve(1, 32'h100, 0, 32'hDEAD3344);
        chk("evict_rdata", dcache_rdata, 32'hDEAD3344);
        tick();

        // force_miss on a valid line refetches and updates it.
        issue(32'h100, 1, 1, 0, 0);
        chk("fm_stall", dcache_stall, 1);
        serve(0, 32'h100, 0, 32'h5);
        chk("fm_rdata", dcache_rdata, 32'h5);
        fmiss = 1'b0;
        tick();
        issue(32'h100, 1, 0, 0, 0);
        chk("fm_line_hit", dcache_stall, 0);
        tick();
        chk("fm_line_data", dcache_rdata, 32'h5);
        tick();

        // Ack withheld for 10 cycles.
        issue(32'h300, 1, 0, 0, 0);
        serve(10, 32'h300, 0, 32'h33333333);
        chk("slow_rdata", dcache_rdata, 32'h33333333);
        tick();

        // Stray ack while idle changes nothing.
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        tick();
        mem_ack = 1'b0; mem_rdata = '0; #1;
        chk("stray_req", mem_req, 0); chk("stray_rvalid", dcache_rvalid, 0);
        chk("stray_stall", dcache_stall, 0); chk("stray_rdata", dcache_rdata, 32'h33333333);
        issue(32'h300, 1, 0, 0, 0);
        chk("stray_hit", dcache_stall, 0);
        tick();
        chk("stray_line", dcache_rdata, 32'h33333333);
        tick();

        // Async reset in READ drops the request; a late ack is ignored.
        issue(32'h500, 1, 0, 0, 0);
        tick();
        chk("rr_req_up", mem_req, 1);
        #2; grst = 1'b1; #1;
        chk("rr_req_drop", mem_req, 0); chk("rr_stall_drop", dcache_stall, 0);
        mem_ack = 1'b1; mem_rdata = 32'hBAD1BAD1;
        tick();
        grst = 1'b0;
        tick();
        mem_ack = 1'b0; mem_rdata = '0; #1;
        chk("rr_late_req", mem_req, 0); chk("rr_late_rvalid", dcache_rvalid, 0);
        chk("rr_late_stall", dcache_stall, 0);
        issue(32'h104, 1, 0, 0, 0);
        chk("rr_reload_miss", dcache_stall, 1);
        serve(0, 32'h104, 0, 32'h77);
        chk("rr_reload_rdata", dcache_rdata, 32'h77);
        tick();

        // Store miss does not allocate.
        issue(32'h208, 0, 0, 32'hA5A5A5A5, 4'b1111);
        serve(0, 32'h208, 1, 0);
        tick();
        issue(32'h208, 1, 0, 0, 0);
        chk("noalloc_miss", dcache_stall, 1);
        serve(0, 32'h208, 0, 32'hA5A5A5A5);
        chk("noalloc_rdata", dcache_rdata, 32'hA5A5A5A5);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
